// File: rtl/text_buffer_uart_dump_if.sv
// Dump-side bundle: buffer read port, dump control handshake and UART line.
// The master modport is the dump engine; the slave side is the buffer/host.
interface text_buffer_uart_dump_if;
    localparam int unsigned LINE_W = 2;
    localparam int unsigned COL_W  = 4;
    localparam int unsigned DATA_W = 8;

    logic              dump_start;
    logic [LINE_W-1:0] rd_line;
    logic [COL_W-1:0]  rd_col;
    logic [DATA_W-1:0] rd_data;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        input  dump_start,
        input  rd_data,
        output rd_line,
        output rd_col,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output dump_start,
        output rd_data,
        input  rd_line,
        input  rd_col,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/text_buffer_uart_dump.sv
// Reads the LINES x COLS text buffer in raster order and streams it as UART 8N1,
// appending CR LF after every line so a terminal mirrors the on-screen text.
module text_buffer_uart_dump #(
    parameter int unsigned BAUD_DIV = 10417,
    parameter int unsigned LINES    = 4,
    parameter int unsigned COLS     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    text_buffer_uart_dump_if.master bus
);
    localparam int unsigned LINE_W = 2;
    localparam int unsigned COL_W  = 4;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned CNT_W  = $clog2(BAUD_DIV);

    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);

    localparam logic [7:0] CH_MIN  = 8'h20;
    localparam logic [7:0] CH_MAX  = 8'h7E;
    localparam logic [7:0] CH_SUBST = 8'h2D;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_ADVANCE
    } state_t;

    typedef enum logic [1:0] {
        K_CHAR,
        K_CR,
        K_LF
    } kind_t;

    state_t            state, state_d;
    kind_t             kind_q, kind_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BIT_W-1:0]  bit_nxt;
    logic [7:0]        shreg_q, shreg_d;
    logic [7:0]        char_byte;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_done;
    logic              last_byte;

    assign baud_done = (baud_q == BAUD_LAST);
    assign bit_nxt   = bit_q + BIT_W'(1);
    assign last_byte = (kind_q == K_LF) && (line_q == LINE_LAST);

    // Non-printable buffer entries are shown as '-' so the terminal stays aligned.
    always_comb begin
        char_byte = CH_SUBST;
        if (bus.rd_data >= CH_MIN && bus.rd_data <= CH_MAX) begin
            char_byte = bus.rd_data;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:    if (bus.dump_start) state_d = S_FETCH;
            S_FETCH:   state_d = S_WAIT;
            S_WAIT:    state_d = S_LOAD;
            S_LOAD:    state_d = S_START;
            S_START:   if (baud_done) state_d = S_DATA;
            S_DATA:    if (baud_done && bit_q == BIT_LAST) state_d = S_STOP;
            S_STOP:    if (baud_done) state_d = S_ADVANCE;
            S_ADVANCE: state_d = last_byte ? S_IDLE : S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; tx is precomputed so the line changes on the state edge.
    always_comb begin
        kind_d  = kind_q;
        line_d  = line_q;
        col_d   = col_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        baud_d  = (state_d != state || baud_done) ? '0 : baud_q + CNT_W'(1);

        unique case (state)
            S_IDLE: begin
                if (bus.dump_start) begin
                    busy_d = 1'b1;
                    line_d = '0;
                    col_d  = '0;
                    kind_d = K_CHAR;
                end
            end
            S_LOAD: begin
                unique case (kind_q)
                    K_CR:    shreg_d = CH_CR;
                    K_LF:    shreg_d = CH_LF;
                    default: shreg_d = char_byte;
                endcase
                bit_d = '0;
                tx_d  = 1'b0;
            end
            S_START: begin
                tx_d = baud_done ? shreg_q[0] : 1'b0;
            end
            S_DATA: begin
                tx_d = shreg_q[bit_q];
                if (baud_done) begin
                    bit_d = bit_nxt;
                    tx_d  = (bit_q == BIT_LAST) ? 1'b1 : shreg_q[bit_nxt];
                end
            end
            S_ADVANCE: begin
                unique case (kind_q)
                    K_CHAR: begin
                        if (col_q == COL_LAST) begin
                            kind_d = K_CR;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                    K_CR: kind_d = K_LF;
                    default: begin
                        if (line_q == LINE_LAST) begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                            line_d = '0;
                            col_d  = '0;
                            kind_d = K_CHAR;
                        end else begin
                            line_d = line_q + LINE_W'(1);
                            col_d  = '0;
                            kind_d = K_CHAR;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kind_q  <= K_CHAR;
            line_q  <= '0;
            col_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            kind_q  <= kind_d;
            line_q  <= line_d;
            col_q   <= col_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.rd_line = line_q;
    assign bus.rd_col  = col_q;
    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_text_buffer_uart_dump.sv
// Bench for text_buffer_uart_dump: buffer model, UART decoder and expected-stream model.
module tb_text_buffer_uart_dump;
    localparam int unsigned BD         = 4;
    localparam int          FRAME      = 10 * BD + 4;
    localparam int          DUMP_CYC   = 72 * FRAME;
    localparam int          DUMP_BYTES = 72;

    logic clk;
    logic reset;
    text_buffer_uart_dump_if bus ();

    text_buffer_uart_dump #(.BAUD_DIV(BD), .LINES(4), .COLS(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;

    logic [7:0] mem [64];
    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         done_q [$];
    int         busy_fall_q [$];
    int         done_hi   = 0;
    int         tx_low    = 0;
    int         frame_err = 0;
    logic       done_prev = 1'b0;
    logic       busy_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read buffer: data appears one clock after the address.
    always @(posedge clk) bus.rd_data <= mem[{bus.rd_line, bus.rd_col}];

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_hi++;
            if (done_prev !== 1'b1) done_q.push_back(cyc);
        end
        if (busy_prev === 1'b1 && bus.busy === 1'b0) busy_fall_q.push_back(cyc);
        if (bus.tx !== 1'b1) tx_low++;
        done_prev = bus.done;
        busy_prev = bus.busy;
    end

    // UART 8N1 receiver sampling bit centres; a reset aborts the frame.
    initial begin : decoder
        logic       prev;
        logic [7:0] b;
        logic       stop_bit;
        bit         ok;
        int         s;
        int         k;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && prev === 1'b1 && bus.tx === 1'b0) begin
                s = cyc;
                ok = 1'b1;
                b = '0;
                stop_bit = 1'b0;
                for (int n = 1; n <= 9 * int'(BD) + 1; n++) begin
                    @(negedge clk);
                    if (reset === 1'b1) begin
                        ok = 1'b0;
                        break;
                    end
                    if (n > int'(BD) && (n % int'(BD)) == 1) begin
                        k = n / int'(BD) - 1;
                        if (k < 8) b[k] = bus.tx;
                        else stop_bit = bus.tx;
                    end
                end
                if (ok) begin
                    rx_q.push_back(b);
                    rx_t.push_back(s);
                    if (stop_bit !== 1'b1) frame_err++;
                end
            end
            prev = bus.tx;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            miss++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    // Expected terminal stream: each line's printable characters then CR LF.
    task automatic build_expected();
        logic [7:0] c;
        for (int l = 0; l < 4; l++) begin
            for (int col = 0; col < 16; col++) begin
                c = mem[l * 16 + col];
                exp_q.push_back((c >= 8'h20 && c <= 8'h7E) ? c : 8'h2D);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic clear_mon();
        exp_q.delete();
        rx_q.delete();
        rx_t.delete();
        done_q.delete();
        busy_fall_q.delete();
        done_hi = 0;
        frame_err = 0;
    endtask

    task automatic start_dump(output int acc);
        @(negedge clk);
        bus.dump_start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        bus.dump_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && done_q.size() < n; i++) @(negedge clk);
        check({tag, "_done_seen"}, done_q.size() >= n, 1);
    endtask

    task automatic check_stream(input string tag);
        int n;
        check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        check({tag, "_framing"}, frame_err, 0);
    endtask

    initial begin
        int acc;
        int t0;
        int low0;
        int target;

        for (int i = 0; i < 64; i++) mem[i] = 8'h20;
        bus.dump_start = 1'b0;
        bus.rd_data    = '0;
        reset = 1'b1;
        #1;
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_line", bus.rd_line, 0);
        check("rst_col", bus.rd_col, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle without a request: line stays high and nothing is transmitted.
        clear_mon();
        low0 = tx_low;
        repeat (60) @(negedge clk);
        check("idle_tx_low", tx_low - low0, 0);
        check("idle_bytes", rx_q.size(), 0);
        check("idle_busy", bus.busy, 0);
        check("idle_done", done_hi, 0);

        // All 'A'
        for (int i = 0; i < 64; i++) mem[i] = 8'h41;
        clear_mon();
        build_expected();
        start_dump(acc);
        check("a_busy", bus.busy, 1);
        wait_done("a", 1, DUMP_CYC + 200);
        repeat (5) @(negedge clk);
        check_stream("a");
        check("a_first_start", (rx_t.size() > 0) ? rx_t[0] - acc : -1, 3);
        check("a_done_time", (done_q.size() > 0) ? done_q[0] - acc : -1, DUMP_CYC);
        check("a_busy_fall", (busy_fall_q.size() > 0) ? busy_fall_q[0] - acc : -1, DUMP_CYC);
        check("a_done_width", done_hi, 1);
        check("a_frame_pitch", (rx_t.size() > 1) ? rx_t[1] - rx_t[0] : -1, FRAME);

        // Printable-range boundaries
        for (int i = 0; i < 64; i++) mem[i] = 8'h20;
        mem[16] = 8'h1F;
        mem[37] = 8'h7F;
        mem[63] = 8'h80;
        clear_mon();
        build_expected();
        start_dump(acc);
        wait_done("bnd", 1, DUMP_CYC + 200);
        repeat (5) @(negedge clk);
        check_stream("bnd");

        // Random contents with a second request mid-dump that must be ignored.
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[$urandom_range(0, 63)] = 8'h7E;
        clear_mon();
        build_expected();
        start_dump(acc);
        repeat (100) @(negedge clk);
        bus.dump_start = 1'b1;
        @(negedge clk);
        bus.dump_start = 1'b0;
        wait_done("ign", 1, DUMP_CYC + 200);
        repeat (300) @(negedge clk);
        check_stream("ign");
        check("ign_done_pulses", done_q.size(), 1);
        check("ign_busy_after", bus.busy, 0);

        // Reset during DATA of byte 20 (line 1 col 2 holds '@', bit 2 is 0).
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(32, 126));
        mem[18] = 8'h40;
        clear_mon();
        start_dump(acc);
        target = acc + 20 * FRAME + 3 + 3 * int'(BD);
        for (int i = 0; i < DUMP_CYC && cyc < target; i++) @(negedge clk);
        check("mid_tx_before", bus.tx, 0);
        #1 reset = 1'b1;
        #1;
        check("mid_tx_async", bus.tx, 1);
        check("mid_busy_async", bus.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        check("mid_bytes_before_rst", rx_q.size(), 20);
        low0 = tx_low;
        t0 = rx_q.size();
        repeat (200) @(negedge clk);
        check("mid_idle_tx_low", tx_low - low0, 0);
        check("mid_idle_bytes", rx_q.size() - t0, 0);
        check("mid_idle_done", done_hi, 0);
        clear_mon();
        build_expected();
        start_dump(acc);
        wait_done("rst", 1, DUMP_CYC + 200);
        repeat (5) @(negedge clk);
        check_stream("rst");
        check("rst_first_start", (rx_t.size() > 0) ? rx_t[0] - acc : -1, 3);

        // dump_start held: two back-to-back dumps.
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        clear_mon();
        build_expected();
        build_expected();
        @(negedge clk);
        bus.dump_start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        wait_done("b2b1", 1, DUMP_CYC + 200);
        for (int i = 0; i < 10 && bus.busy !== 1'b1; i++) @(negedge clk);
        bus.dump_start = 1'b0;
        wait_done("b2b2", 2, DUMP_CYC + 200);
        repeat (300) @(negedge clk);
        check_stream("b2b");
        check("b2b_done_pulses", done_q.size(), 2);
        check("b2b_done_width", done_hi, 2);
        check("b2b_done1_time", (done_q.size() > 0) ? done_q[0] - acc : -1, DUMP_CYC);
        check("b2b_done_spacing", (done_q.size() > 1) ? done_q[1] - done_q[0] : -1, DUMP_CYC + 1);
        check("b2b_second_start",
              (rx_t.size() > DUMP_BYTES && done_q.size() > 0) ? rx_t[DUMP_BYTES] - done_q[0] : -1, 4);
        check("b2b_busy_after", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
